// File: rtl/latch_seq_pkg.sv
// Shared types and defaults for the latch enable sequencer.
// State encoding is fixed at 2 bits so it can be probed directly.
package latch_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    PULSE = 2'd2,
    HOLD  = 2'd3
  } seq_state_t;

  localparam int SEQ_SLOTS_DEF = 4;
  localparam int SEQ_WIDTH_DEF = 1;

endpackage

// File: rtl/slot_ctr.sv
// Wrap-around slot index counter with synchronous clear.
// SLOTS is a power of two, so natural binary overflow gives the modulo wrap.
module slot_ctr #(
  parameter  int SLOTS = 4,
  localparam int SW    = $clog2(SLOTS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inc,
  input  logic          clr,
  output logic [SW-1:0] count,
  output logic          last
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (inc) begin
      count <= count + SW'(1);
    end
  end

  assign last = (count == SW'(SLOTS - 1));

endmodule

// File: rtl/latch_en_sequencer.sv
// Feeds a bank of enabled latches: each accepted word gets one cycle of di setup,
// a one-cycle enable pulse on the current slot, and one cycle of di hold.
module latch_en_sequencer
  import latch_seq_pkg::*;
#(
  parameter  int WIDTH = SEQ_WIDTH_DEF,
  parameter  int SLOTS = SEQ_SLOTS_DEF,
  localparam int SW    = $clog2(SLOTS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             flush,
  output logic [WIDTH-1:0] di,
  output logic [SLOTS-1:0] en,
  output logic [SW-1:0]    slot,
  output logic             busy,
  output logic             done,
  output seq_state_t       state_dbg
);

  // Handshake: a word transfers on any rising edge where in_valid and
  // in_ready are both 1; in_data must stay stable until that edge.

  seq_state_t state_q;
  seq_state_t state_d;
  logic       fire;
  logic       slot_inc;
  logic       slot_last;
  logic [SLOTS-1:0] en_decode;

  slot_ctr #(.SLOTS(SLOTS)) u_slot_ctr (
    .clk   (clk),
    .rst   (rst),
    .inc   (slot_inc),
    .clr   (flush),
    .count (slot),
    .last  (slot_last)
  );

  assign fire      = in_valid && in_ready;
  assign slot_inc  = (state_q == HOLD) && !flush;
  assign en_decode = SLOTS'(1) << slot;
  assign state_dbg = state_q;

  always_comb begin
    in_ready = 1'b0;
    state_d  = state_q;
    case (state_q)
      IDLE: begin
        in_ready = !rst && !flush;
        if (in_valid && !rst && !flush) state_d = SETUP;
      end
      SETUP:   state_d = PULSE;
      PULSE:   state_d = HOLD;
      HOLD:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (flush) state_d = IDLE;
  end

  // Outputs are registered from next-state so they line up with the state they describe.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      di      <= '0;
      en      <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      busy    <= (state_d != IDLE);
      en      <= (state_d == PULSE) ? en_decode : '0;
      done    <= (state_d == HOLD) && slot_last;
      if (fire) di <= in_data;
    end
  end

endmodule
